// File: rtl/cache_mem_arbiter_pkg.sv
// Shared constants for the cache/DMA SDRAM host-port arbiter: FSM encodings, port indices
// and counter widths.
package cache_mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 24;
    localparam int unsigned NUM_PORTS      = 3;

    localparam int unsigned PORT_DC  = 2;
    localparam int unsigned PORT_IC  = 1;
    localparam int unsigned PORT_DMA = 0;

    // Width of the per-word mem_done wait counter.
    localparam int unsigned TO_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef logic [NUM_PORTS-1:0] port_vec_t;

endpackage

// File: rtl/cache_mem_arbiter_prio_pick.sv
// Combinational winner select: starving requesters (lowest index first) beat the fixed
// dcache > icache > DMA priority. One-hot output, all-zero when nothing requests.
module cache_mem_arbiter_prio_pick
    import cache_mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] starving,
    output logic [2:0] winner
);

    logic [2:0] starve_req;

    always_comb begin
        winner     = '0;
        starve_req = req & starving;
        if (starve_req[PORT_DMA]) begin
            winner[PORT_DMA] = 1'b1;
        end else if (starve_req[PORT_IC]) begin
            winner[PORT_IC] = 1'b1;
        end else if (starve_req[PORT_DC]) begin
            winner[PORT_DC] = 1'b1;
        end else if (req[PORT_DC]) begin
            winner[PORT_DC] = 1'b1;
        end else if (req[PORT_IC]) begin
            winner[PORT_IC] = 1'b1;
        end else if (req[PORT_DMA]) begin
            winner[PORT_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the SDRAM host port between dcache, icache and DMA; the granted requester's line
// is transferred as LINE_WORDS single-word accesses, critical word first.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW           = MEM_ADDR_WIDTH,
    parameter int unsigned LINE_WORDS   = 4,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    rd_req,
    input  logic [2:0]    wr_req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [31:0]   wdata2,
    output logic [2:0]    grant,
    output logic [2:0]    word_ack,
    output logic [2:0]    line_done,
    output logic [31:0]   rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_done,
    output logic          timeout_err
);

    localparam int unsigned L  = $clog2(LINE_WORDS);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]      state_q, state_d;
    port_vec_t       grant_q, grant_d;
    port_vec_t       ack_q, ack_d;
    port_vec_t       done_q, done_d;
    logic            dir_q, dir_d;
    logic            strobe_q, strobe_d;
    logic            terr_q, terr_d;
    logic [AW-1:0]   base_q, base_d;
    logic [L-1:0]    word_cnt_q, word_cnt_d;
    logic [L-1:0]    word_lo;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [SW-1:0]   starve_q [NUM_PORTS];
    logic [SW-1:0]   starve_d [NUM_PORTS];

    port_vec_t       req;
    port_vec_t       starving;
    port_vec_t       pick;
    logic [AW-1:0]   pick_addr;
    logic [31:0]     owner_wdata;
    logic            last_word;
    logic            wait_expired;

    assign req          = rd_req | wr_req;
    assign last_word    = (word_cnt_q == L'(LINE_WORDS - 1));
    assign wait_expired = (tcnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            starving[i] = (starve_q[i] >= SW'(STARVE_LIMIT));
        end
    end

    cache_mem_arbiter_prio_pick u_prio_pick (
        .req      (req),
        .starving (starving),
        .winner   (pick)
    );

    always_comb begin
        pick_addr   = ({AW{pick[PORT_DC]}}     & addr2)
                    | ({AW{pick[PORT_IC]}}     & addr1)
                    | ({AW{pick[PORT_DMA]}}    & addr0);
        owner_wdata = ({32{grant_q[PORT_DC]}}  & wdata2)
                    | ({32{grant_q[PORT_IC]}}  & wdata1)
                    | ({32{grant_q[PORT_DMA]}} & wdata0);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        done_d     = '0;
        dir_d      = dir_q;
        strobe_d   = strobe_q;
        terr_d     = terr_q;
        base_d     = base_q;
        word_cnt_d = word_cnt_q;
        tcnt_d     = tcnt_q;
        rdata_d    = rdata_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            starve_d[i] = starve_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d    = pick;
                    dir_d      = |(wr_req & pick);
                    base_d     = pick_addr;
                    word_cnt_d = '0;
                    tcnt_d     = '0;
                    strobe_d   = 1'b1;
                    state_d    = ST_ISSUE;
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        if (pick[i]) begin
                            starve_d[i] = '0;
                        end else if (req[i] && !starving[i]) begin
                            starve_d[i] = starve_q[i] + SW'(1);
                        end
                    end
                end
            end
            ST_ISSUE: begin
                // Later words re-raise the strobe here, leaving a one-cycle gap after mem_done.
                strobe_d = 1'b1;
                tcnt_d   = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done) begin
                    strobe_d = 1'b0;
                    ack_d    = grant_q;
                    rdata_d  = mem_rdata;
                    if (last_word) begin
                        done_d  = grant_q;
                        state_d = ST_FINISH;
                    end else begin
                        word_cnt_d = word_cnt_q + L'(1);
                        state_d    = ST_ISSUE;
                    end
                end else if (wait_expired) begin
                    strobe_d = 1'b0;
                    terr_d   = 1'b1;
                    done_d   = grant_q;
                    state_d  = ST_FINISH;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            ST_FINISH: begin
                grant_d    = '0;
                word_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            dir_q      <= 1'b0;
            strobe_q   <= 1'b0;
            terr_q     <= 1'b0;
            base_q     <= '0;
            word_cnt_q <= '0;
            tcnt_q     <= '0;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                starve_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            dir_q      <= dir_d;
            strobe_q   <= strobe_d;
            terr_q     <= terr_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            tcnt_q     <= tcnt_d;
            rdata_q    <= rdata_d;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

    // Word offset wraps inside the line; the carry never reaches the upper address bits.
    assign word_lo     = base_q[L-1:0] + word_cnt_q;
    assign mem_addr    = {base_q[AW-1:L], word_lo};
    assign mem_rd      = strobe_q & ~dir_q;
    assign mem_wr      = strobe_q & dir_q;
    assign mem_wdata   = mem_wr ? owner_wdata : 32'h0;
    assign grant       = grant_q;
    assign word_ack    = ack_q;
    assign line_done   = done_q;
    assign rdata       = rdata_q;
    assign timeout_err = terr_q;

endmodule
